// File: rtl/matmult_sched.sv
// Round-robin scheduler sharing one matmult engine among NREQ requesters.
// Define MATMULT_SCHED_TIMEOUT_EN to enable the WAIT-state watchdog (timeout_err).
module matmult_sched #(
    parameter int NREQ = 4,
    parameter int IDXW = 2
`ifdef MATMULT_SCHED_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 64
`endif
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req_valid,
    output logic [NREQ-1:0] req_grant,
    output logic [IDXW-1:0] sel,
    output logic [NREQ-1:0] done_valid,
    input  logic [NREQ-1:0] done_accept,
    output logic            mm_ready,
    input  logic            mm_valid,
    output logic            mm_accept,
    output logic            busy,
    output logic [15:0]     job_count,
    output logic            timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_WAIT  = 3'd2,
        S_RESP  = 3'd3,
        S_ACK   = 3'd4,
        S_DRAIN = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [IDXW-1:0] r_sel;
    logic [IDXW-1:0] r_ptr;
    logic [15:0]     r_job_count;
    logic [NREQ-1:0] w_rot;
    logic [NREQ-1:0] w_onehot;
    logic [IDXW:0]   w_sum;
    logic [IDXW-1:0] w_pick;
    logic            w_found;
    logic            w_timeout;

    // Rotate requests so bit 0 is the requester at ptr; first set bit wins.
    assign w_rot = NREQ'({req_valid, req_valid} >> r_ptr);

    always_comb begin
        w_found = 1'b0;
        w_pick  = r_ptr;
        w_sum   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && w_rot[i]) begin
                w_found = 1'b1;
                w_sum   = {1'b0, r_ptr} + (IDXW+1)'(i);
                if (w_sum >= (IDXW+1)'(NREQ))
                    w_sum = w_sum - (IDXW+1)'(NREQ);
                w_pick  = w_sum[IDXW-1:0];
            end
        end
    end

`ifdef MATMULT_SCHED_TIMEOUT_EN
    logic [15:0] r_wcnt;
    logic        r_timeout_err;

    assign w_timeout   = (r_wcnt == 16'(TIMEOUT - 1));
    assign timeout_err = r_timeout_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wcnt        <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state == S_LOAD)
                r_wcnt <= '0;
            else if (r_state == S_WAIT)
                r_wcnt <= r_wcnt + 16'd1;
            if (r_state == S_WAIT && !mm_valid && w_timeout)
                r_timeout_err <= 1'b1;
        end
    end
`else
    assign w_timeout   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_next = S_LOAD;
            S_LOAD:  w_next = S_WAIT;
            S_WAIT:  if (mm_valid || w_timeout) w_next = S_RESP;
            S_RESP:  if (done_accept[r_sel]) w_next = S_ACK;
            S_ACK:   w_next = S_DRAIN;
            // Engine shows a stale valid here; it is deliberately ignored.
            S_DRAIN: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sel       <= '0;
            r_ptr       <= '0;
            r_job_count <= '0;
        end else begin
            if (r_state == S_IDLE && w_found)
                r_sel <= w_pick;
            if (r_state == S_ACK) begin
                r_job_count <= r_job_count + 16'd1;
                r_ptr       <= (r_sel == IDXW'(NREQ - 1)) ? '0 : r_sel + 1'b1;
            end
        end
    end

    assign w_onehot   = NREQ'(1) << r_sel;
    assign sel        = r_sel;
    assign req_grant  = (r_state == S_LOAD || r_state == S_WAIT ||
                         r_state == S_RESP || r_state == S_ACK) ? w_onehot : '0;
    assign done_valid = (r_state == S_RESP) ? w_onehot : '0;
    assign mm_ready   = (r_state == S_LOAD);
    assign mm_accept  = (r_state == S_ACK);
    assign busy       = (r_state != S_IDLE);
    assign job_count  = r_job_count;

endmodule

// File: tb/tb_matmult_sched.sv
// Directed bench for matmult_sched with a cycle-accurate engine model
// (start -> calc -> fin, registered valid, one stale valid cycle after accept).
module tb_matmult_sched;
    localparam int NREQ = 4;
    localparam int IDXW = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NREQ-1:0] req_valid = '0;
    logic [NREQ-1:0] req_grant;
    logic [IDXW-1:0] sel;
    logic [NREQ-1:0] done_valid;
    logic [NREQ-1:0] done_accept = '0;
    logic            mm_ready;
    logic            mm_valid;
    logic            mm_accept;
    logic            busy;
    logic [15:0]     job_count;
    logic            timeout_err;

    int checks = 0;
    int failures = 0;

    logic [1:0] e_state;
    logic       e_stall = 1'b0;

    logic [IDXW-1:0] exp_q[$];

    matmult_sched #(.NREQ(NREQ), .IDXW(IDXW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_grant(req_grant),
        .sel(sel), .done_valid(done_valid), .done_accept(done_accept),
        .mm_ready(mm_ready), .mm_valid(mm_valid), .mm_accept(mm_accept),
        .busy(busy), .job_count(job_count), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Engine model: idle(0) -> calc(1) -> fin(2) until accept; valid is registered.
    always @(posedge clk) begin
        if (!rst_n) begin
            e_state  <= 2'd0;
            mm_valid <= 1'b0;
        end else begin
            mm_valid <= (e_state == 2'd2);
            case (e_state)
                2'd0:    if (mm_ready && !e_stall) e_state <= 2'd1;
                2'd1:    e_state <= 2'd2;
                2'd2:    if (mm_accept) e_state <= 2'd0;
                default: e_state <= 2'd0;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int last_load;
        int seen;
        logic [IDXW-1:0] e;

        // Reset state
        tick(2);
        check("rst_grant", req_grant, 0);
        check("rst_sel", sel, 0);
        check("rst_done", done_valid, 0);
        check("rst_ready", mm_ready, 0);
        check("rst_accept", mm_accept, 0);
        check("rst_busy", busy, 0);
        check("rst_count", job_count, 0);
        check("rst_terr", timeout_err, 0);
        rst_n = 1'b1;
        tick();

        // Single job for requester 1; drops request right after grant
        req_valid = 4'b0010;
        tick();
        check("j1_ready", mm_ready, 1);
        check("j1_grant", req_grant, 4'b0010);
        check("j1_sel", sel, 1);
        check("j1_busy", busy, 1);
        req_valid = 4'b0000;
        tick();
        check("j1_ready_pulse", mm_ready, 0);
        tick(2);
        check("j1_mmvalid_t4", mm_valid, 1);
        check("j1_done_t4", done_valid, 0);
        tick();
        check("j1_done_t5", done_valid, 4'b0010);
        check("j1_grant_resp", req_grant, 4'b0010);
        check("j1_noaccept", mm_accept, 0);
        done_accept = 4'b0010;
        tick();
        check("j1_mm_accept", mm_accept, 1);
        check("j1_grant_ack", req_grant, 4'b0010);
        done_accept = 4'b0000;
        tick();
        check("j1_drain_stale", mm_valid, 1);
        check("j1_drain_ready", mm_ready, 0);
        check("j1_drain_grant", req_grant, 0);
        check("j1_drain_busy", busy, 1);
        check("j1_count", job_count, 1);
        tick();
        check("j1_idle", busy, 0);
        check("j1_idle_done", done_valid, 0);

        // Slow consumer: ptr=2 wraps to requester 0; other accept bits ignored
        req_valid = 4'b0001;
        tick();
        check("j2_sel", sel, 0);
        check("j2_ready", mm_ready, 1);
        req_valid = 4'b0000;
        tick(4);
        check("j2_done", done_valid, 4'b0001);
        req_valid = 4'b0100;
        done_accept = 4'b1110;
        for (int c = 0; c < 20; c++) begin
            tick();
            check("slow_done_held", done_valid, 4'b0001);
            check("slow_no_accept", mm_accept, 0);
            check("slow_engine_fin", mm_valid, 1);
            check("slow_no_grant", req_grant, 4'b0001);
        end
        done_accept = 4'b0001;
        tick();
        check("j2_mm_accept", mm_accept, 1);
        done_accept = 4'b0000;
        tick();
        check("drain_stale_valid", mm_valid, 1);
        check("drain_no_ready", mm_ready, 0);
        check("j2_count", job_count, 2);
        tick();
        check("drain_to_idle", busy, 0);
        check("idle_no_done", done_valid, 0);
        tick();
        check("j3_load_gap", mm_ready, 1);
        check("j3_sel", sel, 2);
        check("j3_grant", req_grant, 4'b0100);
        req_valid = 4'b0000;

        // Reset while in WAIT
        tick(2);
        check("j3_wait_busy", busy, 1);
        rst_n = 1'b0;
        tick();
        check("midrst_grant", req_grant, 0);
        check("midrst_sel", sel, 0);
        check("midrst_busy", busy, 0);
        check("midrst_ready", mm_ready, 0);
        check("midrst_done", done_valid, 0);
        check("midrst_count", job_count, 0);

        // Contention: all requesters, accept held; order 0,1,2,3,0 every 8 cycles
        rst_n = 1'b1;
        req_valid = 4'b1111;
        done_accept = 4'b1111;
        exp_q = {2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        last_load = 0;
        seen = 0;
        for (int c = 0; c < 48; c++) begin
            tick();
            check("rr_onehot", ($countones(req_grant) <= 1), 1);
            if (mm_ready) begin
                if (exp_q.size() == 0) begin
                    check("rr_extra_grant", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rr_sel", sel, e);
                    check("rr_grant", req_grant, 4'b0001 << e);
                    if (seen > 0) check("rr_period", c - last_load, 8);
                end
                last_load = c;
                seen++;
                if (seen == 5) req_valid = 4'b0000;
            end
        end
        check("rr_all_granted", exp_q.size(), 0);
        check("rr_count", job_count, 5);
        check("rr_idle", busy, 0);

        // Stalled engine: requester 3 (ptr=1, first set bit at/after it)
        done_accept = 4'b0000;
        e_stall = 1'b1;
        req_valid = 4'b1000;
        tick();
        check("stall_sel", sel, 3);
        req_valid = 4'b0000;
`ifdef MATMULT_SCHED_TIMEOUT_EN
        tick(64);
        check("to_wait_done", done_valid, 0);
        check("to_wait_flag", timeout_err, 0);
        check("to_wait_grant", req_grant, 4'b1000);
        tick();
        check("to_done", done_valid, 4'b1000);
        check("to_flag", timeout_err, 1);
        done_accept = 4'b1000;
        tick();
        done_accept = 4'b0000;
        tick(2);
        e_stall = 1'b0;
        req_valid = 4'b0001;
        tick();
        check("to_next_sel", sel, 0);
        req_valid = 4'b0000;
        tick(4);
        check("to_next_done", done_valid, 4'b0001);
        check("to_sticky_resp", timeout_err, 1);
        done_accept = 4'b0001;
        tick();
        done_accept = 4'b0000;
        tick(2);
        check("to_count", job_count, 7);
        check("to_sticky_idle", timeout_err, 1);
`else
        tick(100);
        check("hold_done", done_valid, 0);
        check("hold_grant", req_grant, 4'b1000);
        check("hold_busy", busy, 1);
        check("hold_terr", timeout_err, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        e_stall = 1'b0;
        check("hold_rst_busy", busy, 0);
        check("hold_rst_terr", timeout_err, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
